// File: rtl/bpu_btb_bht_queue.sv
// Dual-slot BTB + 2-bit BHT branch predictor with an in-flight prediction queue popped at resolve.
// Optional gshare indexing (global history XOR pc) is enabled by defining BPU_GSHARE_EN.
module bpu_btb_bht_queue #(
  parameter int         BTB_ENTRIES = 64,
  parameter int         BHT_ENTRIES = 256,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         QDEPTH      = 8,
  parameter int         GHR_W       = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_current_pc,
  input  logic        i_fetch_valid,
  output logic        o_prd_taken,
  output logic [31:0] o_prd_target,
  output logic        o_prd_slot,
  output logic        o_q_full,
  output logic        o_q_empty,
  input  logic        i_br_update_en,
  input  logic        i_br_update_taken,
  input  logic [31:0] i_br_update_pc,
  input  logic [31:0] i_br_update_target,
  input  logic        i_flush,
  output logic        o_prd_miss_t,
  output logic        o_prd_miss_nt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int BI_W  = $clog2(BHT_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam int QP_W  = $clog2(QDEPTH);
  localparam logic [QP_W:0] QFULL = (QP_W+1)'(QDEPTH);

  typedef struct packed {
    logic [31:0]     pc;
    logic [BI_W-1:0] idx;
    logic            taken;
  } q_entry_t;

  function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else    res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
    return res;
  endfunction

  logic [BTB_ENTRIES-1:0] btb_valid_r;
  logic [TAG_W-1:0]       btb_tag_r [BTB_ENTRIES];
  logic [31:0]            btb_tgt_r [BTB_ENTRIES];
  logic [1:0]             bht_r     [BHT_ENTRIES];
  q_entry_t               q_r       [QDEPTH];
  logic [QP_W-1:0]        head_r;
  logic [QP_W-1:0]        tail_r;
  logic [QP_W:0]          count_r;

  logic [31:0]      pc1_s;
  logic [31:0]      sel_pc_s;
  logic [IDX_W-1:0] bidx0_s;
  logic [IDX_W-1:0] bidx1_s;
  logic [IDX_W-1:0] bidx_upd_s;
  logic [BI_W-1:0]  hidx0_s;
  logic [BI_W-1:0]  hidx1_s;
  logic [BI_W-1:0]  hidx_upd_s;
  logic [BI_W-1:0]  hidx_sel_s;
  logic [BI_W-1:0]  cnt_idx_s;
  logic             hit0_s;
  logic             hit1_s;
  logic             hit_s;
  q_entry_t         head_s;
  logic             q_full_s;
  logic             q_empty_s;
  logic             head_match_s;
  logic             prd_s;
  logic             pop_s;
  logic             push_s;

  assign pc1_s      = i_current_pc + 32'd4;
  assign bidx0_s    = i_current_pc[IDX_W+1:2];
  assign bidx1_s    = pc1_s[IDX_W+1:2];
  assign bidx_upd_s = i_br_update_pc[IDX_W+1:2];

`ifdef BPU_GSHARE_EN
  logic [GHR_W-1:0] ghr_r;
  logic [BI_W-1:0]  hist_s;

  // History sits in the upper index bits, zero-padded below.
  assign hist_s     = BI_W'(ghr_r) << (BI_W - GHR_W);
  assign hidx0_s    = i_current_pc[BI_W+1:2] ^ hist_s;
  assign hidx1_s    = pc1_s[BI_W+1:2] ^ hist_s;
  assign hidx_upd_s = i_br_update_pc[BI_W+1:2] ^ hist_s;

  // Non-speculative global history: shifts on every resolved branch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) ghr_r <= {GHR_W{1'b0}};
    else if (i_br_update_en) ghr_r <= {ghr_r[GHR_W-2:0], i_br_update_taken};
  end
`else
  assign hidx0_s    = i_current_pc[BI_W+1:2];
  assign hidx1_s    = pc1_s[BI_W+1:2];
  assign hidx_upd_s = i_br_update_pc[BI_W+1:2];
`endif

  assign hit0_s = btb_valid_r[bidx0_s] & (btb_tag_r[bidx0_s] == i_current_pc[31:IDX_W+2]);
  assign hit1_s = btb_valid_r[bidx1_s] & (btb_tag_r[bidx1_s] == pc1_s[31:IDX_W+2]);
  assign hit_s  = hit0_s | hit1_s;

  // Slot selection and prediction; slot0 wins when both slots hit.
  always_comb begin
    sel_pc_s     = i_current_pc;
    hidx_sel_s   = hidx0_s;
    o_prd_taken  = 1'b0;
    o_prd_target = 32'd0;
    o_prd_slot   = 1'b0;
    if (hit0_s) begin
      o_prd_taken  = bht_r[hidx0_s][1];
      o_prd_target = btb_tgt_r[bidx0_s];
    end else if (hit1_s) begin
      sel_pc_s     = pc1_s;
      hidx_sel_s   = hidx1_s;
      o_prd_taken  = bht_r[hidx1_s][1];
      o_prd_target = btb_tgt_r[bidx1_s];
      o_prd_slot   = 1'b1;
    end else begin
      sel_pc_s     = i_current_pc;
      hidx_sel_s   = hidx0_s;
    end
  end

  assign q_full_s      = (count_r == QFULL);
  assign q_empty_s     = (count_r == (QP_W+1)'(0));
  assign o_q_full      = q_full_s;
  assign o_q_empty     = q_empty_s;
  assign head_s        = q_r[head_r];
  assign head_match_s  = ~q_empty_s & (head_s.pc == i_br_update_pc);
  assign prd_s         = head_match_s & head_s.taken;
  assign pop_s         = i_br_update_en & head_match_s;
  // A same-cycle pop frees the slot, so a full queue may still accept a push.
  assign push_s        = i_fetch_valid & hit_s & ~i_flush & (~q_full_s | pop_s);
  assign cnt_idx_s     = head_match_s ? head_s.idx : hidx_upd_s;
  assign o_prd_miss_t  = i_br_update_en & ~i_br_update_taken & prd_s;
  assign o_prd_miss_nt = i_br_update_en & i_br_update_taken & ~prd_s;

  // BTB: direct-mapped, written only by taken branches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btb_valid_r <= {BTB_ENTRIES{1'b0}};
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag_r[i] <= {TAG_W{1'b0}};
        btb_tgt_r[i] <= 32'd0;
      end
    end else if (i_br_update_en & i_br_update_taken) begin
      btb_valid_r[bidx_upd_s] <= 1'b1;
      btb_tag_r[bidx_upd_s]   <= i_br_update_pc[31:IDX_W+2];
      btb_tgt_r[bidx_upd_s]   <= i_br_update_target;
    end
  end

  // BHT: trains the counter used at fetch time when the head matches.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_r[i] <= CNT_INIT;
    end else if (i_br_update_en) begin
      bht_r[cnt_idx_s] <= sat_cnt(bht_r[cnt_idx_s], i_br_update_taken);
    end
  end

  // Queue storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < QDEPTH; i++) q_r[i] <= {$bits(q_entry_t){1'b0}};
    end else if (push_s) begin
      q_r[tail_r] <= '{pc: sel_pc_s, idx: hidx_sel_s, taken: o_prd_taken};
    end
  end

  // Queue pointers and occupancy; flush empties the queue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r  <= {QP_W{1'b0}};
      tail_r  <= {QP_W{1'b0}};
      count_r <= {(QP_W+1){1'b0}};
    end else if (i_flush) begin
      head_r  <= {QP_W{1'b0}};
      tail_r  <= {QP_W{1'b0}};
      count_r <= {(QP_W+1){1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + QP_W'(1);
      if (pop_s)  head_r <= head_r + QP_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (QP_W+1)'(1);
        2'b01:   count_r <= count_r - (QP_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_bpu_btb_bht_queue.sv
// Self-checking bench for bpu_btb_bht_queue: directed scenarios plus randomized traffic
// compared against a behavioural model (counters as integers 0..3, queue as a SV queue).
module tb_bpu_btb_bht_queue;

  localparam int QD = 8;

  logic        clk;
  logic        rst;
  logic [31:0] cur_pc;
  logic        fetch_valid;
  logic        upd_en;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic [31:0] upd_tgt;
  logic        flush;
  logic        prd_taken;
  logic [31:0] prd_target;
  logic        prd_slot;
  logic        q_full;
  logic        q_empty;
  logic        miss_t;
  logic        miss_nt;

  bpu_btb_bht_queue dut (
    .i_clk(clk), .i_rst(rst), .i_current_pc(cur_pc), .i_fetch_valid(fetch_valid),
    .o_prd_taken(prd_taken), .o_prd_target(prd_target), .o_prd_slot(prd_slot),
    .o_q_full(q_full), .o_q_empty(q_empty),
    .i_br_update_en(upd_en), .i_br_update_taken(upd_taken), .i_br_update_pc(upd_pc),
    .i_br_update_target(upd_tgt), .i_flush(flush),
    .o_prd_miss_t(miss_t), .o_prd_miss_nt(miss_nt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          idx;
    logic        taken;
  } ent_t;

  logic        m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int          m_cnt   [256];
  ent_t        m_q     [$];
`ifdef BPU_GSHARE_EN
  int          m_ghr;
`endif

  logic        e_taken, e_slot, e_full, e_empty, e_mt, e_mnt, e_push, e_hm;
  logic [31:0] e_target;
  ent_t        e_ent;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pool [6] = '{32'h100, 32'hFC, 32'h104, 32'h200, 32'h2100, 32'h3FC};

  function automatic int bidx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % 256);
`ifdef BPU_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return i;
  endfunction

  function automatic int bslot(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic logic m_hit(input logic [31:0] pc);
    return m_valid[bslot(pc)] && (m_tag[bslot(pc)] == (pc >> 8));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0;
    end
    for (int i = 0; i < 256; i++) m_cnt[i] = 1;
    m_q.delete();
`ifdef BPU_GSHARE_EN
    m_ghr = 0;
`endif
  endtask

  task automatic model_eval();
    logic h0, h1, prd;
    logic [31:0] sp;
    h0 = m_hit(cur_pc);
    h1 = m_hit(cur_pc + 32'd4);
    sp = h0 ? cur_pc : cur_pc + 32'd4;
    e_slot   = !h0 && h1;
    e_taken  = (h0 || h1) && (m_cnt[bidx(sp)] >= 2);
    e_target = (h0 || h1) ? m_tgt[bslot(sp)] : 32'd0;
    e_full   = (m_q.size() == QD);
    e_empty  = (m_q.size() == 0);
    e_hm     = (m_q.size() > 0) && (m_q[0].pc == upd_pc);
    prd      = e_hm && m_q[0].taken;
    e_mt     = upd_en && !upd_taken && prd;
    e_mnt    = upd_en && upd_taken && !prd;
    e_push   = fetch_valid && (h0 || h1) && !flush && (!e_full || (upd_en && e_hm));
    e_ent.pc = sp; e_ent.idx = bidx(sp); e_ent.taken = e_taken;
  endtask

  task automatic model_commit();
    int k;
    model_eval();
    if (upd_en) begin
      k = e_hm ? m_q[0].idx : bidx(upd_pc);
      if (upd_taken) begin
        if (m_cnt[k] < 3) m_cnt[k]++;
        m_valid[bslot(upd_pc)] = 1'b1;
        m_tag[bslot(upd_pc)]   = upd_pc >> 8;
        m_tgt[bslot(upd_pc)]   = upd_tgt;
      end else if (m_cnt[k] > 0) begin
        m_cnt[k]--;
      end
`ifdef BPU_GSHARE_EN
      m_ghr = ((m_ghr << 1) | int'(upd_taken)) % 256;
`endif
    end
    if (flush) m_q.delete();
    else begin
      if (upd_en && e_hm) void'(m_q.pop_front());
      if (e_push) m_q.push_back(e_ent);
    end
  endtask

  task automatic idle();
    fetch_valid = 1'b0; upd_en = 1'b0; upd_taken = 1'b0;
    upd_pc = 32'd0; upd_tgt = 32'd0; flush = 1'b0;
  endtask

  task automatic tick();
    model_commit();
    @(negedge clk);
  endtask

  task automatic test_reset(input string tag);
    rst = 1'b1; idle(); cur_pc = 32'h100; model_reset();
    #1;
    checks++; if (prd_taken !== 1'b0) begin errors++; $display("FAIL %s_taken got=%0b want=0", tag, prd_taken); end
    checks++; if (prd_target !== 32'd0) begin errors++; $display("FAIL %s_target got=%0h want=0", tag, prd_target); end
    checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL %s_empty got=%0b want=1", tag, q_empty); end
    checks++; if (q_full !== 1'b0) begin errors++; $display("FAIL %s_full got=%0b want=0", tag, q_full); end
    checks++; if ({miss_t, miss_nt, prd_slot} !== 3'b000) begin errors++; $display("FAIL %s_misc got=%0b want=000", tag, {miss_t, miss_nt, prd_slot}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_train();
    idle(); cur_pc = 32'h100; upd_en = 1'b1; upd_taken = 1'b1; upd_pc = 32'h100; upd_tgt = 32'h200;
    #1;
    checks++; if (miss_nt !== 1'b1) begin errors++; $display("FAIL train_miss_nt got=%0b want=1", miss_nt); end
    checks++; if (miss_t !== 1'b0) begin errors++; $display("FAIL train_miss_t got=%0b want=0", miss_t); end
    tick();
    idle(); cur_pc = 32'h100;
    #1;
    checks++; if (prd_taken !== 1'b1) begin errors++; $display("FAIL train_taken got=%0b want=1", prd_taken); end
    checks++; if (prd_target !== 32'h200) begin errors++; $display("FAIL train_target got=%0h want=200", prd_target); end
    checks++; if (prd_slot !== 1'b0) begin errors++; $display("FAIL train_slot got=%0b want=0", prd_slot); end
    tick();
  endtask

  task automatic test_slot1();
    idle(); cur_pc = 32'hFC; fetch_valid = 1'b1;
    #1;
    checks++; if (prd_slot !== 1'b1) begin errors++; $display("FAIL slot1_slot got=%0b want=1", prd_slot); end
    checks++; if (prd_taken !== 1'b1) begin errors++; $display("FAIL slot1_taken got=%0b want=1", prd_taken); end
    checks++; if (prd_target !== 32'h200) begin errors++; $display("FAIL slot1_target got=%0h want=200", prd_target); end
    tick();
    idle(); upd_en = 1'b1; upd_taken = 1'b0; upd_pc = 32'h100;
    #1;
    checks++; if (q_empty !== 1'b0) begin errors++; $display("FAIL slot1_queued got=%0b want=0", q_empty); end
    checks++; if (miss_t !== 1'b1) begin errors++; $display("FAIL slot1_miss_t got=%0b want=1", miss_t); end
    tick();
    idle(); cur_pc = 32'h100;
    #1;
    checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL slot1_popped got=%0b want=1", q_empty); end
    checks++; if (prd_taken !== 1'b0) begin errors++; $display("FAIL slot1_cnt_dec got=%0b want=0", prd_taken); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < QD; i++) begin
      idle(); cur_pc = 32'h100; fetch_valid = 1'b1;
      #1;
      tick();
    end
    idle(); cur_pc = 32'h100; fetch_valid = 1'b1;
    #1;
    checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full_after8 got=%0b want=1", q_full); end
    tick();
    idle(); cur_pc = 32'h100; fetch_valid = 1'b1; upd_en = 1'b1; upd_taken = 1'b1; upd_pc = 32'h100; upd_tgt = 32'h200;
    #1;
    checks++; if (q_full !== 1'b1) begin errors++; $display("FAIL full_drop9 got=%0b want=1", q_full); end
    checks++; if (miss_nt !== 1'b1) begin errors++; $display("FAIL full_pp_miss_nt got=%0b want=1", miss_nt); end
    tick();
    for (int i = 0; i < QD; i++) begin
      idle(); upd_en = 1'b1; upd_taken = 1'b0; upd_pc = 32'h100;
      #1;
      checks++; if (q_empty !== 1'b0) begin errors++; $display("FAIL full_drain%0d got=%0b want=0", i, q_empty); end
      checks++; if (q_full !== (i == 0)) begin errors++; $display("FAIL full_level%0d got=%0b want=%0b", i, q_full, (i == 0)); end
      tick();
    end
    idle();
    #1;
    checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL full_drained got=%0b want=1", q_empty); end
    tick();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      idle(); cur_pc = 32'h100; fetch_valid = 1'b1;
      #1;
      tick();
    end
    idle(); cur_pc = 32'h100; fetch_valid = 1'b1; flush = 1'b1;
    upd_en = 1'b1; upd_taken = 1'b1; upd_pc = 32'h100; upd_tgt = 32'h200;
    #1; model_eval();
    checks++; if (q_empty !== 1'b0) begin errors++; $display("FAIL flush_pre_empty got=%0b want=0", q_empty); end
    checks++; if (miss_nt !== e_mnt) begin errors++; $display("FAIL flush_miss_nt got=%0b want=%0b", miss_nt, e_mnt); end
    tick();
    idle(); cur_pc = 32'h100;
    #1; model_eval();
    checks++; if (q_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%0b want=1", q_empty); end
    checks++; if (prd_taken !== e_taken) begin errors++; $display("FAIL flush_cnt got=%0b want=%0b", prd_taken, e_taken); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      idle();
      cur_pc      = pool[$urandom_range(0, 5)];
      fetch_valid = ($urandom_range(0, 9) < 6);
      upd_en      = ($urandom_range(0, 1) == 1);
      upd_taken   = ($urandom_range(0, 1) == 1);
      if (m_q.size() > 0 && $urandom_range(0, 9) < 7) upd_pc = m_q[0].pc;
      else upd_pc = pool[$urandom_range(0, 5)];
      upd_tgt = 32'($urandom_range(0, 1023)) << 2;
      flush   = ($urandom_range(0, 19) == 0);
      #1; model_eval();
      checks++; if (prd_taken !== e_taken) begin errors++; $display("FAIL rnd_taken c=%0d got=%0b want=%0b", c, prd_taken, e_taken); end
      checks++; if (prd_target !== e_target) begin errors++; $display("FAIL rnd_target c=%0d got=%0h want=%0h", c, prd_target, e_target); end
      checks++; if (prd_slot !== e_slot) begin errors++; $display("FAIL rnd_slot c=%0d got=%0b want=%0b", c, prd_slot, e_slot); end
      checks++; if (q_full !== e_full) begin errors++; $display("FAIL rnd_full c=%0d got=%0b want=%0b", c, q_full, e_full); end
      checks++; if (q_empty !== e_empty) begin errors++; $display("FAIL rnd_empty c=%0d got=%0b want=%0b", c, q_empty, e_empty); end
      checks++; if (miss_t !== e_mt) begin errors++; $display("FAIL rnd_miss_t c=%0d got=%0b want=%0b", c, miss_t, e_mt); end
      checks++; if (miss_nt !== e_mnt) begin errors++; $display("FAIL rnd_miss_nt c=%0d got=%0b want=%0b", c, miss_nt, e_mnt); end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    idle(); cur_pc = 32'h100; upd_en = 1'b1; upd_taken = 1'b1; upd_pc = 32'h100; upd_tgt = 32'h300;
    #1;
    tick();
    for (int i = 0; i < 2; i++) begin
      idle(); cur_pc = 32'h100; fetch_valid = 1'b1;
      #1;
      tick();
    end
    idle(); cur_pc = 32'h100;
    #1;
    checks++; if (q_empty !== 1'b0) begin errors++; $display("FAIL midrst_loaded got=%0b want=0", q_empty); end
    test_reset("midrst");
  endtask

  initial begin
    test_reset("reset");
    test_train();
    test_slot1();
    test_full();
    test_flush();
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
